// File: rtl/ifetch_unit.sv
// Instruction-fetch front end: drives the combinational instruction memory, buffers words
// in a 2-entry FIFO for decode, and handles start, redirects and halt.
// Optional IFETCH_STATS_EN adds a saturating fetch_cnt output that counts decode handshakes.
module ifetch_unit #(
    parameter int                 ADDR_W    = 6,
    parameter int                 INSTR_W   = 32,
    parameter logic [INSTR_W-1:0] HALT_WORD = 32'hD4400000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    input  logic               br_valid,
    input  logic [ADDR_W-1:0]  br_target,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic               halted
`ifdef IFETCH_STATS_EN
    ,
    output logic [15:0]        fetch_cnt
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_HALT
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [ADDR_W-1:0]   pc;
    logic [INSTR_W-1:0]  fifo_instr [2];
    logic [ADDR_W-1:0]   fifo_pc    [2];
    logic                rd_ptr;
    logic                wr_ptr;
    logic [1:0]          count;
    logic                pop;
    logic                redirect;
    logic                fetch_en;
    logic                fetch;
    logic                is_halt;
    logic                push;

    // A pop in the same cycle frees a slot, so a full FIFO can still accept a fetch.
    assign pop      = instr_valid && instr_ready;
    assign redirect = br_valid && (state != S_IDLE);
    assign is_halt  = (imem_data == HALT_WORD);
    assign fetch    = fetch_en && !redirect && ((count < 2'd2) || pop);
    assign push     = fetch && !is_halt;

    assign imem_addr   = pc;
    assign instr_valid = (count != 2'd0);
    assign instr       = instr_valid ? fifo_instr[rd_ptr] : '0;
    assign instr_pc    = instr_valid ? fifo_pc[rd_ptr]    : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (!redirect && fetch && is_halt) begin
                    state_nxt = S_HALT;
                end
            end
            S_HALT: begin
                if (redirect) begin
                    state_nxt = S_RUN;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        halted   = (state == S_HALT);
        fetch_en = (state == S_RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= '0;
        end else if (redirect) begin
            pc <= br_target;
        end else if (push) begin
            pc <= pc + 1'b1;
        end
    end

    // A redirect discards everything left after this cycle's handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                fifo_instr[i] <= '0;
                fifo_pc[i]    <= '0;
            end
        end else if (redirect) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                fifo_instr[wr_ptr] <= imem_data;
                fifo_pc[wr_ptr]    <= pc;
                wr_ptr             <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

`ifdef IFETCH_STATS_EN
    logic [15:0] stat_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_cnt <= '0;
        end else if (pop && (stat_cnt != 16'hFFFF)) begin
            stat_cnt <= stat_cnt + 16'd1;
        end
    end

    assign fetch_cnt = stat_cnt;
`endif

endmodule

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
- Instruction-fetch front end that drives the word address of the 64x32 combinational instruction memory and captures the returned instruction word.
- Buffers fetched words in a 2-entry FIFO and presents them to decode with a valid/ready handshake.
- Handles branch redirects, a start pulse, and halt detection.
- Sits between the instruction memory and the decode/register-file stage of the LEGv8 datapath.

Parameters:
- ADDR_W, 6, word-address width; the memory holds 2^ADDR_W words.
- INSTR_W, 32, instruction width.
- HALT_WORD, 32'hD4400000, instruction encoding that halts fetch.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; leaves IDLE and begins fetching at address 0
- imem_addr  out  ADDR_W  word address to the instruction memory; always equals pc
- imem_data  in  INSTR_W  memory read data, valid in the same cycle (combinational memory)
- br_valid  in  1  redirect request
- br_target  in  ADDR_W  redirect word address
- instr_valid  out  1  FIFO head is valid
- instr_ready  in  1  decode accepts the head
- instr  out  INSTR_W  head instruction
- instr_pc  out  ADDR_W  word address of the head instruction
- halted  out  1  high while in HALT

Behaviour:
- Reset is asynchronous and active-low: while rst_n=0, the FSM is in IDLE, pc=0, the FIFO is empty, instr_valid=0, instr=0, instr_pc=0, halted=0, imem_addr=0.
- FSM states:
  - IDLE: no fetch. A start pulse moves to RUN; pc stays 0.
  - RUN: fetch each cycle the FIFO can accept, i.e. when count<2, or count==2 with a pop in the same cycle.
    - On a fetch, if imem_data != HALT_WORD: push {pc, imem_data} and set pc <= pc+1.
    - On a fetch, if imem_data == HALT_WORD: do not push, hold pc, go to HALT.
  - HALT: no fetch. halted=1. The FIFO still drains through the handshake.
    - br_valid moves to RUN with pc <= br_target.
    - start is ignored.
- Latency:
  - The word at address A is visible on instr/instr_pc one cycle after pc==A is fetched.
  - After a start pulse in cycle t, instr_valid=1 at cycle t+2 with instr_pc=0.
- Handshake:
  - The head pops at a rising edge when instr_valid and instr_ready are both 1.
  - instr and instr_pc are stable while instr_valid=1 and instr_ready=0.
  - FIFO order is strictly preserved.
- Redirect:
  - br_valid is sampled in RUN and HALT; it is ignored in IDLE.
  - At the edge: a handshake in the same cycle completes first, then the FIFO is flushed (count=0), pc <= br_target, and no push occurs that cycle.
  - instr_valid=0 in the following cycle. The target word is presented one cycle after that.
  - br_valid has priority over the fetch and over halt detection in the same cycle.
- Wrap-around: pc is ADDR_W bits, so pc=63 increments to 0 with no flag.
- Full FIFO: with count==2 and no pop, the fetch stalls and pc holds.
- Simultaneous push and pop with count==2: allowed, count stays 2.
- Reset mid-operation: the FIFO is discarded immediately and pc returns to 0.

Optional Feature:
- IFETCH_STATS_EN defined:
  - Adds output fetch_cnt (16 bits).
  - Increments on every accepted decode handshake and saturates at 16'hFFFF.
  - Resets to 0 on reset only; a redirect does not clear it.
- Not defined: the port and the counter are absent. All other behaviour is identical.

Test Plan:
- Memory holds 8B1F03E5, F84000A4, 8B040086, F80010A6, HALT_WORD at addresses 0-4, and instr_ready=1.
  - Pulse start, then expect the four words on consecutive cycles with instr_pc 0,1,2,3.
  - halted=1 once address 4 is fetched; instr_valid=0 after the FIFO drains.
- Hold instr_ready=0 for 5 cycles after start:
  - instr_valid=1 with instr=8B1F03E5 held stable.
  - pc stops at 2 (FIFO full).
  - Releasing ready resumes delivery in order 0,1,2.
- Assert br_valid with br_target=10 while the FIFO holds addresses 1,2 and instr_ready=1:
  - The address-1 handshake completes and address 2 is flushed.
  - Next cycle instr_valid=0; the cycle after, instr_pc=10.
- Load HALT_WORD only at address 63, then redirect to 62: expect address 62 delivered, then halted=1.
  - Repeat with a non-halt word at address 63: instr_pc sequence 62,63,0.
- Assert rst_n=0 asynchronously mid-stream with a full FIFO: instr_valid=0 and imem_addr=0 immediately, without waiting for a clock edge.
  - After release, nothing is fetched until start.
- With IFETCH_STATS_EN defined: after the first scenario, fetch_cnt=4.
  - After a forced preload of 16'hFFFE and 3 handshakes, fetch_cnt=16'hFFFF.
